// File: rtl/coax_tx_arbiter.sv
// coax_tx_arbiter: shares one buffered coax transmitter between the host command
// path (req0) and the poll generator (req1). It grants the transmitter one whole
// frame at a time, round-robin. It streams the granted requester's words into the
// transmitter FIFO, starts transmission and waits for it to finish. It then holds
// off for an inter-frame gap before granting again.
//
// state          | meaning
// ---------------|--------------------------------------------------------------
// S_IDLE         | no frame in progress; grant on any valid request
// S_LOAD         | granted requester's words handed to the FIFO until `last`
// S_START        | last word loaded; start strobe issued on the following clock
// S_WAIT_ACTIVE  | waiting for tx_active to rise, bounded by START_TIMEOUT
// S_WAIT_DONE    | transmitter serialising; done pulse when tx_active falls
// S_GAP          | enforced idle of GAP_CLOCKS cycles; requests ignored
module coax_tx_arbiter #(
    parameter int DEPTH         = 8,
    parameter int GAP_CLOCKS    = 16,
    parameter int START_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] req0_data,
    input  logic       req0_valid,
    input  logic       req0_last,
    output logic       req0_ready,
    output logic       req0_done,
    input  logic [9:0] req1_data,
    input  logic       req1_valid,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       req1_done,
    output logic [9:0] tx_data,
    output logic       tx_load_strobe,
    output logic       tx_start_strobe,
    input  logic       tx_active,
    output logic       overflow,
    output logic       timeout
);

    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [15:0]   GAP_LOAD = 16'(GAP_CLOCKS - 1);
    localparam logic [15:0]   TO_LOAD  = 16'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_ACTIVE,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_seen_q, ovf_seen_d;
    logic [15:0]   timer_q, timer_d;
    logic [9:0]    tx_data_q, tx_data_d;
    logic          load_q, load_d;
    logic          start_q, start_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          ovf_q, ovf_d;
    logic          to_q, to_d;

    logic          sel_valid;
    logic          sel_last;
    logic [9:0]    sel_data;
    logic          hs;

    // Route the granted requester's word stream and form the handshake.
    always_comb begin
        sel_valid = grant_q ? req1_valid : req0_valid;
        sel_last  = grant_q ? req1_last  : req0_last;
        sel_data  = grant_q ? req1_data  : req0_data;
        hs        = (state_q == S_LOAD) && sel_valid;
    end

    assign req0_ready      = (state_q == S_LOAD) && !grant_q;
    assign req1_ready      = (state_q == S_LOAD) &&  grant_q;
    assign tx_data         = tx_data_q;
    assign tx_load_strobe  = load_q;
    assign tx_start_strobe = start_q;
    assign req0_done       = done0_q;
    assign req1_done       = done1_q;
    assign overflow        = ovf_q;
    assign timeout         = to_q;

    // Next-state and registered-output decode; pulses default low every cycle.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        ovf_seen_d   = ovf_seen_q;
        timer_d      = timer_q;
        tx_data_d    = tx_data_q;
        load_d       = 1'b0;
        start_d      = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        ovf_d        = 1'b0;
        to_d         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d      = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
                    last_grant_d = grant_d;
                    cnt_d        = '0;
                    ovf_seen_d   = 1'b0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    if (cnt_q < DEPTH_C) begin
                        tx_data_d = sel_data;
                        load_d    = 1'b1;
                        cnt_d     = cnt_q + CW'(1);
                    end else if (!ovf_seen_q) begin
                        // Saturated count: word is swallowed, flag only the first one.
                        ovf_d      = 1'b1;
                        ovf_seen_d = 1'b1;
                    end
                    if (sel_last) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                // Registered strobe lands one clock after the final load strobe.
                start_d = 1'b1;
                timer_d = TO_LOAD;
                state_d = S_WAIT_ACTIVE;
            end
            S_WAIT_ACTIVE: begin
                if (tx_active) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == '0) begin
                    to_d    = 1'b1;
                    timer_d = GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_active) begin
                    done0_d = !grant_q;
                    done1_d =  grant_q;
                    timer_d = GAP_LOAD;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            ovf_seen_q   <= 1'b0;
            timer_q      <= '0;
            tx_data_q    <= '0;
            load_q       <= 1'b0;
            start_q      <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            ovf_q        <= 1'b0;
            to_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            ovf_seen_q   <= ovf_seen_d;
            timer_q      <= timer_d;
            tx_data_q    <= tx_data_d;
            load_q       <= load_d;
            start_q      <= start_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            ovf_q        <= ovf_d;
            to_q         <= to_d;
        end
    end

endmodule

// File: tb/tb_coax_tx_arbiter.sv
// Directed bench for coax_tx_arbiter: requester word sources and a tx_active
// responder are stepped once per clock; expected values are hand-computed.
module tb_coax_tx_arbiter;

    localparam int GAP  = 16;
    localparam int TOUT = 64;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] req0_data, req1_data;
    logic       req0_valid, req1_valid, req0_last, req1_last;
    logic       req0_ready, req1_ready, req0_done, req1_done;
    logic [9:0] tx_data;
    logic       tx_load_strobe, tx_start_strobe, tx_active, overflow, timeout;

    always #5 clk = ~clk;

    coax_tx_arbiter #(.DEPTH(8), .GAP_CLOCKS(GAP), .START_TIMEOUT(TOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last),
        .req0_ready(req0_ready), .req0_done(req0_done),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last),
        .req1_ready(req1_ready), .req1_done(req1_done),
        .tx_data(tx_data), .tx_load_strobe(tx_load_strobe),
        .tx_start_strobe(tx_start_strobe), .tx_active(tx_active),
        .overflow(overflow), .timeout(timeout)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    logic [10:0] q0[$], q1[$];
    int  stall0 = 0, stall_at0 = 0;
    bit  model_en = 1'b1;
    int  act_dly = 0, act_len = 0, fall_cyc = -1;
    int  loads, starts, done0, done1, ovfs, tos, hs0_n, hs1_n;
    int  start_cyc, last_load_cyc, done_cyc, first_done_cyc, to_cyc, ovf_cyc, hs_last_cyc, hs9_cyc;
    int  r1_viol;
    logic [9:0] load_data[$];
    int  load_cyc[$], rise_who[$], rise_cyc[$];
    bit  p0 = 1'b0, p1 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        loads = 0; starts = 0; done0 = 0; done1 = 0; ovfs = 0; tos = 0;
        hs0_n = 0; hs1_n = 0; r1_viol = 0;
        start_cyc = -1; last_load_cyc = -1; done_cyc = -1; first_done_cyc = -1;
        to_cyc = -1; ovf_cyc = -1; hs_last_cyc = -1; hs9_cyc = -1;
        load_data.delete(); load_cyc.delete(); rise_who.delete(); rise_cyc.delete();
    endtask

    task automatic drive_src();
        if (stall0 > 0) begin
            stall0--;
            req0_valid = 1'b0;
        end else begin
            req0_valid = (q0.size() != 0);
        end
        req0_data  = (q0.size() != 0) ? q0[0][9:0] : 10'h0;
        req0_last  = (q0.size() != 0) ? q0[0][10]  : 1'b0;
        req1_valid = (q1.size() != 0);
        req1_data  = (q1.size() != 0) ? q1[0][9:0] : 10'h0;
        req1_last  = (q1.size() != 0) ? q1[0][10]  : 1'b0;
    endtask

    // One clock: advance sources on handshakes, observe outputs, model tx_active.
    task automatic tick();
        bit hs0, hs1;
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (hs0 && q0.size() != 0) begin
            hs0_n++;
            if (q0[0][10]) hs_last_cyc = cyc;
            void'(q0.pop_front());
        end
        if (hs1 && q1.size() != 0) begin
            hs1_n++;
            if (hs1_n == 9) hs9_cyc = cyc;
            if (q1[0][10]) hs_last_cyc = cyc;
            void'(q1.pop_front());
        end
        if (tx_load_strobe) begin
            loads++;
            load_data.push_back(tx_data);
            load_cyc.push_back(cyc);
            last_load_cyc = cyc;
        end
        if (act_len > 0) begin
            act_len--;
            if (act_len == 0) begin
                tx_active = 1'b0;
                fall_cyc  = cyc;
            end
        end else if (act_dly > 0) begin
            act_dly--;
            if (act_dly == 0) begin
                tx_active = 1'b1;
                act_len   = 100;
            end
        end
        if (tx_start_strobe) begin
            starts++;
            start_cyc = cyc;
            if (model_en) act_dly = 3;
        end
        if (req0_done || req1_done) begin
            if (first_done_cyc < 0) first_done_cyc = cyc;
            done_cyc = cyc;
        end
        if (req0_done) done0++;
        if (req1_done) done1++;
        if (overflow) begin ovfs++; ovf_cyc = cyc; end
        if (timeout)  begin tos++;  to_cyc  = cyc; end
        if (req0_ready && !p0) begin rise_who.push_back(0); rise_cyc.push_back(cyc); end
        if (req1_ready && !p1) begin rise_who.push_back(1); rise_cyc.push_back(cyc); end
        if (req1_ready && done0 == 0) r1_viol++;
        p0 = req0_ready;
        p1 = req1_ready;
        if (stall_at0 != 0 && hs0_n == stall_at0) begin
            stall0    = 5;
            stall_at0 = 0;
        end
        drive_src();
    endtask

    function automatic logic [31:0] outs();
        return {14'h0, req0_ready, req1_ready, req0_done, req1_done, tx_data,
                tx_load_strobe, tx_start_strobe, overflow, timeout};
    endfunction

    initial begin
        reset_n = 1'b0; tx_active = 1'b0;
        req0_data = '0; req0_valid = 1'b0; req0_last = 1'b0;
        req1_data = '0; req1_valid = 1'b0; req1_last = 1'b0;
        clr();
        repeat (3) tick();
        chk("reset_outputs", outs(), 32'h0);

        // Single frame from req0.
        clr();
        q0.push_back({1'b0, 10'h175}); q0.push_back({1'b0, 10'h28E}); q0.push_back({1'b1, 10'h175});
        drive_src();
        reset_n = 1'b1;
        for (int i = 0; i < 400 && done0 < 1; i++) tick();
        chk("single_loads", loads, 3);
        if (load_data.size() == 3) begin
            chk("single_w0", load_data[0], 10'h175);
            chk("single_w1", load_data[1], 10'h28E);
            chk("single_w2", load_data[2], 10'h175);
            chk("single_b2b", load_cyc[2] - load_cyc[0], 2);
        end
        chk("single_starts", starts, 1);
        chk("single_start_lat", start_cyc, last_load_cyc + 1);
        chk("single_done0", done0, 1);
        chk("single_done1", done1, 0);
        chk("single_done_lat", done_cyc, fall_cyc + 1);
        repeat (GAP + 2) tick();

        // Contention from reset release: expect req0, req1, req0.
        reset_n = 1'b0;
        q0.delete(); q1.delete();
        repeat (2) tick();
        clr();
        q0.push_back({1'b0, 10'h001}); q0.push_back({1'b1, 10'h002});
        q0.push_back({1'b0, 10'h005}); q0.push_back({1'b1, 10'h006});
        q1.push_back({1'b0, 10'h003}); q1.push_back({1'b1, 10'h004});
        drive_src();
        reset_n = 1'b1;
        for (int i = 0; i < 1500 && (done0 + done1) < 3; i++) tick();
        chk("cont_grants", rise_who.size(), 3);
        if (rise_who.size() >= 3) begin
            chk("cont_order0", rise_who[0], 0);
            chk("cont_order1", rise_who[1], 1);
            chk("cont_order2", rise_who[2], 0);
            chk("cont_gap", rise_cyc[1] - first_done_cyc, GAP + 1);
        end
        chk("cont_r1_quiet", r1_viol, 0);
        chk("cont_loads", loads, 6);
        if (load_data.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("cont_data", load_data[i], 10'(i + 1));
        end

        // Overflow: 10 words from req1 into an 8-deep FIFO.
        clr();
        for (int i = 0; i < 10; i++) q1.push_back({(i == 9), 10'(10'h300 + i)});
        drive_src();
        for (int i = 0; i < 600 && done1 < 1; i++) tick();
        chk("ovf_loads", loads, 8);
        if (load_data.size() == 8) chk("ovf_w7", load_data[7], 10'h307);
        chk("ovf_pulses", ovfs, 1);
        chk("ovf_on_word9", ovf_cyc, hs9_cyc);
        chk("ovf_starts", starts, 1);
        chk("ovf_start_lat", start_cyc, hs_last_cyc + 1);
        chk("ovf_done1", done1, 1);

        // Timeout: transmitter never goes active; then a normal frame.
        clr();
        model_en = 1'b0;
        q0.push_back({1'b1, 10'h0AA});
        q0.push_back({1'b1, 10'h0BB});
        drive_src();
        for (int i = 0; i < 600 && tos < 1; i++) tick();
        chk("to_pulses", tos, 1);
        chk("to_lat", to_cyc - start_cyc, TOUT);
        chk("to_no_done", done0, 0);
        model_en = 1'b1;
        for (int i = 0; i < 600 && done0 < 1; i++) tick();
        chk("to_regrant", rise_who.size(), 2);
        if (rise_cyc.size() >= 2) chk("to_gap", rise_cyc[1] - to_cyc, GAP + 1);
        chk("to_second_done", done0, 1);
        chk("to_loads", loads, 2);

        // Stall: req0 drops valid for 5 clocks after its 2nd word.
        clr();
        stall_at0 = 2;
        for (int i = 0; i < 5; i++) q0.push_back({(i == 4), 10'(10'h040 + i)});
        drive_src();
        for (int i = 0; i < 600 && done0 < 1; i++) tick();
        chk("stall_loads", loads, 5);
        if (load_cyc.size() == 5) begin
            chk("stall_pre", load_cyc[1] - load_cyc[0], 1);
            chk("stall_hole", load_cyc[2] - load_cyc[1], 6);
            chk("stall_w4", load_data[4], 10'h044);
        end
        chk("stall_done", done0, 1);
        repeat (GAP + 2) tick();

        // Reset mid-frame after two loads, then a fresh frame.
        clr();
        for (int i = 0; i < 5; i++) q0.push_back({(i == 4), 10'(10'h050 + i)});
        drive_src();
        for (int i = 0; i < 300 && loads < 2; i++) tick();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_outputs", outs(), 32'h0);
        q0.delete();
        drive_src();
        repeat (3) tick();
        chk("rst_no_loads", loads, 2);
        chk("rst_no_start", starts, 0);
        chk("rst_no_done", done0, 0);
        clr();
        q0.push_back({1'b0, 10'h011}); q0.push_back({1'b0, 10'h022}); q0.push_back({1'b1, 10'h033});
        drive_src();
        reset_n = 1'b1;
        for (int i = 0; i < 400 && done0 < 1; i++) tick();
        chk("rst_new_loads", loads, 3);
        if (load_data.size() == 3) begin
            chk("rst_new_w0", load_data[0], 10'h011);
            chk("rst_new_w2", load_data[2], 10'h033);
        end
        chk("rst_new_done", done0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coax_tx_arbiter.md
# coax_tx_arbiter

Shares one `coax_buffered_tx` between two frame requesters (host command path and autonomous poll generator). Grants the transmitter round-robin, one whole frame at a time. Streams the granted requester's 10-bit words into the transmitter FIFO, issues the start strobe and waits for transmission to finish. Enforces a minimum inter-frame gap before the next grant.

## Interface

Parameters:
- `DEPTH`, 8: transmitter FIFO depth; maximum words loaded per frame.
- `GAP_CLOCKS`, 16: idle clocks after `tx_active` falls before the next grant; 1..65535.
- `START_TIMEOUT`, 64: clocks allowed from `tx_start_strobe` until `tx_active` rises.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_data`, `req1_data`  in  10  frame word from requester 0 / 1.
- `req0_valid`, `req1_valid`  in  1  word available.
- `req0_last`, `req1_last`  in  1  word is final word of frame; qualified by valid.
- `req0_ready`, `req1_ready`  out  1  word accepted this cycle when valid is also high.
- `req0_done`, `req1_done`  out  1  one-cycle pulse: frame fully transmitted.
- `tx_data`  out  10  word to transmitter.
- `tx_load_strobe`  out  1  one-cycle load pulse for `tx_data`.
- `tx_start_strobe`  out  1  one-cycle start pulse.
- `tx_active`  in  1  transmitter busy serialising.
- `overflow`  out  1  one-cycle pulse: first word beyond `DEPTH` dropped in a frame.
- `timeout`  out  1  one-cycle pulse: `tx_active` failed to rise in time.

## Operation

- States: IDLE, LOAD, START, WAIT_ACTIVE, WAIT_DONE, GAP.
- IDLE: if any `reqN_valid`, grant and enter LOAD.
  - Both valid: grant the requester not granted last.
  - `last_grant` resets to 1, so req0 wins the first contention.
- LOAD:
  - `reqN_ready` = 1 for the granted requester only; combinational from state and grant. The other ready is 0.
  - Each handshake increments word count (0..DEPTH, saturating).
  - If count < DEPTH: register `tx_data` ← word and pulse `tx_load_strobe` next cycle.
  - If count = DEPTH: word is accepted and dropped, no load strobe. `overflow` pulses on the first dropped word only.
  - A handshake with `last` = 1 moves to START.
- START: pulse `tx_start_strobe`; clear the timeout counter; go to WAIT_ACTIVE.
- WAIT_ACTIVE:
  - `tx_active` = 1: go to WAIT_DONE.
  - Counter reaches `START_TIMEOUT`: pulse `timeout`, no done pulse, go to GAP.
- WAIT_DONE: on `tx_active` = 0, pulse granted `reqN_done` and go to GAP.
- GAP: count `GAP_CLOCKS` cycles, then IDLE. Requests are ignored and all readies are 0 during GAP.
- Grant is held for the whole frame; the other requester's valid has no effect until IDLE.
- `reqN_data` is ignored when valid = 0; a stalled requester simply holds LOAD.

## Timing

- Reset (async assert, sync release): state IDLE, counters 0, `last_grant` = 1.
  - All strobes, pulses and readies 0; `tx_data` = 0.
- `tx_load_strobe` follows the accepting handshake edge by exactly 1 clock. Back-to-back handshakes give back-to-back strobes.
- `tx_start_strobe` follows the last-word handshake by 2 clocks, i.e. 1 clock after its load strobe. It is never coincident with a load strobe.
- `reqN_done` asserts the clock after `tx_active` is sampled low in WAIT_DONE.
- Next grant possible exactly `GAP_CLOCKS` + 1 clocks after `reqN_done`.
- Word count resets on entry to LOAD; `overflow` may pulse at most once per frame.
- `reset_n` low mid-frame: immediate return to IDLE; partial frame abandoned; no done pulse; no strobes while reset is low.

## Test plan

- Single frame: req0 sends 3 words 0x175, 0x28E, 0x175 (last on 3rd), `tx_active` modelled 1 from 3 clocks after start for 100 clocks.
  - Expect 3 load strobes with matching `tx_data`, 1 start strobe 1 clock after the 3rd load, then `req0_done` after `tx_active` falls.
- Contention: req0 and req1 both valid at reset release.
  - Expect order req0, req1, req0.
  - Expect ≥ `GAP_CLOCKS` + 1 idle clocks between `reqN_done` and the next `ready`.
  - `req1_ready` stays 0 during req0's frame.
- Overflow: req1 sends 10 words with `DEPTH` = 8.
  - Expect exactly 8 load strobes, one `overflow` pulse on word 9, and a start after word 10.
- Timeout: `tx_active` held 0 after start.
  - Expect `timeout` pulse 64 clocks after `tx_start_strobe`, no `req0_done`, return to IDLE after the gap.
- Stall: req0 drops valid for 5 clocks mid-frame.
  - Expect no load strobes during the stall; frame completes normally.
- Reset mid-frame: assert `reset_n` = 0 after 2 loads.
  - Expect all outputs 0 immediately; a new frame after release loads from word 0.
